// File: rtl/wb_ddr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_ddr_arbiter
//  Description : Two-master Wishbone arbiter in front of the single wb_ddr
//                slave port. Round-robin grant; the owner keeps the bus for
//                the whole of its cyc. A per-transfer watchdog aborts a stalled
//                strobe with a one-cycle err pulse to the owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_ddr_arbiter #(
    parameter int adr_width = 32,
    parameter int dat_width = 32,
    parameter int sel_width = 4,
    parameter int timeout   = 1023,
    parameter int cnt_width = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    // master 0
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_we_i,
    input  logic [adr_width-1:0] m0_adr_i,
    input  logic [dat_width-1:0] m0_dat_i,
    input  logic [sel_width-1:0] m0_sel_i,
    output logic [dat_width-1:0] m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,
    // master 1
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_we_i,
    input  logic [adr_width-1:0] m1_adr_i,
    input  logic [dat_width-1:0] m1_dat_i,
    input  logic [sel_width-1:0] m1_sel_i,
    output logic [dat_width-1:0] m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,
    // slave (wb_ddr)
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [adr_width-1:0] s_adr_o,
    output logic [dat_width-1:0] s_dat_o,
    output logic [sel_width-1:0] s_sel_o,
    input  logic [dat_width-1:0] s_dat_i,
    input  logic                 s_ack_i,
    // current owner, one-hot; 00 = idle
    output logic [1:0]           grant
);

    localparam logic [cnt_width-1:0] c_timeout = cnt_width'(timeout);
    localparam logic [cnt_width-1:0] c_one     = cnt_width'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;      // last master granted
    logic [cnt_width-1:0] wd_q, wd_d;          // cycles the current strobe has waited
    logic                 m0_err_q, m0_err_d;
    logic                 m1_err_q, m1_err_d;

    logic own0_w;
    logic own1_w;

    assign own0_w = (state_q == OWN0);
    assign own1_w = (state_q == OWN1);

    // State, round-robin pointer, watchdog and err pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;   // m0 wins the first tie after reset
            wd_q     <= '0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            wd_q     <= wd_d;
            m0_err_q <= m0_err_d;
            m1_err_q <= m1_err_d;
        end
    end

    // Arbitration, release and watchdog abort decisions
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        wd_d     = '0;
        m0_err_d = 1'b0;
        m1_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On a tie the master that was not served last wins.
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                end else if (m0_stb_i && !s_ack_i) begin
                    // An ack in the boundary cycle takes precedence over abort.
                    if (wd_q == c_timeout) begin
                        state_d  = IDLE;
                        m0_err_d = 1'b1;
                    end else begin
                        wd_d = wd_q + c_one;
                    end
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                end else if (m1_stb_i && !s_ack_i) begin
                    if (wd_q == c_timeout) begin
                        state_d  = IDLE;
                        m1_err_d = 1'b1;
                    end else begin
                        wd_d = wd_q + c_one;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Slave-side mux: owner's signals pass through; idle keeps cyc/stb low
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        if (own0_w) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
        end else if (own1_w) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
        end
    end

    // Ack is steered only to the owner; a late ack while idle is dropped
    assign m0_ack_o = own0_w & s_ack_i;
    assign m1_ack_o = own1_w & s_ack_i;
    assign m0_err_o = m0_err_q;
    assign m1_err_o = m1_err_q;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant    = {own1_w, own0_w};

endmodule
`default_nettype wire

// File: tb/tb_wb_ddr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_ddr_arbiter
//  Description : Directed self-checking bench for wb_ddr_arbiter (timeout=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ddr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_ddr_arbiter #(
        .adr_width(32), .dat_width(32), .sel_width(4), .timeout(8), .cnt_width(4)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant(grant)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = 0; m0_dat_i = 0; m0_sel_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = 0; m1_dat_i = 0; m1_sel_i = 0;
        s_dat_i = 0; s_ack_i = 0;
        tick(); tick();
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_scyc", 32'(s_cyc_o), 32'h0);
        chk("rst_sstb", 32'(s_stb_o), 32'h0);
        chk("rst_err0", 32'(m0_err_o), 32'h0);
        chk("rst_err1", 32'(m1_err_o), 32'h0);
        reset = 1'b0;
        tick();

        // ---- single master burst: 4 writes, ack on 3rd cycle of each ----
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
        m0_adr_i = 32'h100; m0_dat_i = 32'hA0;
        #1;
        chk("sm_grant_pre", 32'(grant), 32'h0);
        tick();
        chk("sm_grant", 32'(grant), 32'h1);
        chk("sm_swe", 32'(s_we_o), 32'h1);
        for (int w = 0; w < 4; w++) begin
            m0_adr_i = 32'h100 + 32'(4 * w);
            m0_dat_i = 32'hA0 + 32'(w);
            tick(); tick();
            s_ack_i = 1;
            #1;
            chk("sm_adr", s_adr_o, 32'h100 + 32'(4 * w));
            chk("sm_sdat", s_dat_o, 32'hA0 + 32'(w));
            chk("sm_ack0", 32'(m0_ack_o), 32'h1);
            chk("sm_ack1", 32'(m1_ack_o), 32'h0);
            tick();
            s_ack_i = 0;
        end
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        chk("sm_release", 32'(grant), 32'h0);

        // ---- round robin after a fresh reset ----
        reset = 1; tick(); reset = 0;
        m0_cyc_i = 1; m1_cyc_i = 1;
        tick();
        chk("rr_first_m0", 32'(grant), 32'h1);
        tick();
        chk("rr_hold_m0", 32'(grant), 32'h1);
        m0_cyc_i = 0;
        tick();
        chk("rr_gap", 32'(grant), 32'h0);
        tick();
        chk("rr_then_m1", 32'(grant), 32'h2);
        m1_cyc_i = 0;
        tick();
        chk("rr_idle2", 32'(grant), 32'h0);
        m0_cyc_i = 1; m1_cyc_i = 1;
        tick();
        chk("rr_alt_m0", 32'(grant), 32'h1);
        m0_cyc_i = 0; m1_cyc_i = 0;
        tick();

        // ---- m1 read ----
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h2000;
        tick();
        chk("rd_grant", 32'(grant), 32'h2);
        chk("rd_adr", s_adr_o, 32'h2000);
        chk("rd_swe", 32'(s_we_o), 32'h0);
        tick();
        s_dat_i = 32'hDEADBEEF; s_ack_i = 1;
        #1;
        chk("rd_dat", m1_dat_o, 32'hDEADBEEF);
        chk("rd_ack1", 32'(m1_ack_o), 32'h1);
        chk("rd_ack0", 32'(m0_ack_o), 32'h0);
        tick();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();

        // ---- watchdog abort (timeout=8) ----
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h300;
        tick();
        chk("wd_stb_seen", 32'(s_stb_o), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("wd_no_err_yet", 32'(m0_err_o), 32'h0);
            chk("wd_cyc_held", 32'(s_cyc_o), 32'h1);
        end
        tick();
        chk("wd_err", 32'(m0_err_o), 32'h1);
        chk("wd_err1", 32'(m1_err_o), 32'h0);
        chk("wd_grant", 32'(grant), 32'h0);
        chk("wd_scyc", 32'(s_cyc_o), 32'h0);
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 1;
        #1;
        chk("wd_late_ack0", 32'(m0_ack_o), 32'h0);
        chk("wd_late_ack1", 32'(m1_ack_o), 32'h0);
        tick();
        s_ack_i = 0;
        chk("wd_pulse_once", 32'(m0_err_o), 32'h0);
        tick();

        // ---- ack exactly at the boundary cycle ----
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        chk("bd_grant", 32'(grant), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("bd_no_err", 32'(m0_err_o), 32'h0);
        end
        s_ack_i = 1;
        #1;
        chk("bd_ack", 32'(m0_ack_o), 32'h1);
        tick();
        s_ack_i = 0;
        chk("bd_err_none", 32'(m0_err_o), 32'h0);
        chk("bd_still_own", 32'(grant), 32'h1);
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        chk("bd_err_none2", 32'(m0_err_o), 32'h0);

        // ---- reset in the middle of an m1 transfer ----
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h400;
        tick();
        chk("mr_grant1", 32'(grant), 32'h2);
        tick();
        reset = 1;
        tick();
        s_ack_i = 1;
        #1;
        chk("mr_grant", 32'(grant), 32'h0);
        chk("mr_scyc", 32'(s_cyc_o), 32'h0);
        chk("mr_ack1", 32'(m1_ack_o), 32'h0);
        chk("mr_err1", 32'(m1_err_o), 32'h0);
        chk("mr_err0", 32'(m0_err_o), 32'h0);
        reset = 0; s_ack_i = 0; m0_cyc_i = 1;
        tick();
        chk("mr_tie_m0", 32'(grant), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
